router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet source for the router input port. A host loads payload bytes into an internal buffer. On start, the block emits the packet as a header byte, then the payload bytes, then a parity byte. Format: header `{len[5:0], addr[1:0]}`; `pkt_valid` is high for header and payload and low for the parity byte. The block honours the router's `busy` back-pressure and sits between the host/test interface and the router's `pkt_valid`/`data_in` inputs.

## Interface
- `MAX_LEN`, default 63: maximum payload bytes; fixed by the 6-bit header length field.
- `DW`, default 8: byte width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write one payload byte into the buffer.
- `wr_data`  in  8  payload byte.
- `start`  in  1  begin transmitting the buffered packet.
- `addr`  in  2  destination port, sampled with `start`.
- `inject_err`  in  1  sampled with `start`; corrupts the parity byte.
- `busy`  in  1  router back-pressure; current byte is held while high.
- `pkt_valid`  out  1  registered; high for header and payload bytes.
- `data_out`  out  8  registered byte to router `data_in`.
- `tx_active`  out  1  high whenever state is not IDLE.
- `tx_done`  out  1  one-cycle pulse after the parity byte is consumed.
- `start_rej`  out  1  one-cycle pulse: start was ignored.
- `wr_drop`  out  1  one-cycle pulse: write was ignored.

## Operation
- Reset values: all outputs 0; state IDLE; `wr_cnt`=0; `pay_par`=0.
- Buffer write: in IDLE, when `wr_en`=1 and `wr_cnt`<63:
  - `buf[wr_cnt]`<=`wr_data`; `wr_cnt`++; `pay_par`^=`wr_data`.
- Dropped writes: `wr_en` outside IDLE, or with `wr_cnt`=63, is ignored and raises `wr_drop`.
- States: IDLE, HDR, PLD, PAR, DONE.
- IDLE:
  - `start` with `wr_cnt`=0: no transition; `start_rej` pulses.
  - `start` with `wr_cnt`>0: latch `hdr={wr_cnt[5:0],addr}` and `par=pay_par^hdr^{7'b0,inject_err}`; clear `rd_ptr`; go to HDR.
- HDR: `data_out`=`hdr`, `pkt_valid`=1.
- PLD: `data_out`=`buf[rd_ptr]`, `pkt_valid`=1.
- PAR: `data_out`=`par`, `pkt_valid`=0.
- Consumption: the byte on the bus is consumed at any edge where `busy`=0. Consumption advances as follows:
  - HDR -> PLD.
  - PLD: `rd_ptr`++; go to PAR after byte number `wr_cnt`.
  - PAR -> DONE.
- `busy`=1: state, `data_out` and `pkt_valid` all hold.
- DONE: `tx_done`=1 for one cycle; `wr_cnt`, `pay_par` and `data_out` cleared to 0; next state IDLE.
- Simultaneous `wr_en` and `start` in IDLE: `start` wins and the write is dropped (`wr_drop`=1).
- `reset` mid-packet: outputs and state go to reset values on the next edge and buffered contents are discarded. A truncated packet (`pkt_valid` falling without a parity byte) is acceptable.

## Timing
- `start` accepted at edge T: header is visible on `data_out` after T.
- With `busy`=0 throughout, packet of length N:
  - header at T+1;
  - payload bytes at T+2..T+N+1;
  - parity at T+N+2, with `pkt_valid` low;
  - `tx_done` at T+N+3;
  - next `start` is accepted at T+N+4 at the earliest.
- Each cycle of `busy`=1 stretches the sequence by exactly one cycle.
- `start_rej` and `wr_drop` are asserted in the cycle after the offending edge.

## Structure
- Shared package `router_pkg` holds:
  - state enum `tx_state_t` {IDLE, HDR, PLD, PAR, DONE};
  - `ADDR_W`=2, `LEN_W`=6, `MAX_LEN`=63;
  - header field positions.
- Sub-module `router_tx_buf`: 64x8 register file with a synchronous write port and a combinational read port addressed by `rd_ptr`. No reset on the array.

## Test plan
- Basic packet: write 0x11, 0x22, 0x33; `start` with `addr`=2 and `busy`=0 -> outputs:
  - `data_out` 0x0E, 0x11, 0x22, 0x33 with `pkt_valid`=1;
  - then 0x0E with `pkt_valid`=0;
  - then `tx_done`=1.
- Back-pressure: same packet with `busy`=1 for 2 cycles while 0x22 is on the bus -> 0x22 is held 3 cycles, and the remaining sequence and parity are unchanged.
- Error injection: same packet with `inject_err`=1 -> parity byte is 0x0F.
- Zero-length start: `start` with an empty buffer -> `start_rej`=1, `tx_active` stays 0, `pkt_valid` stays 0.
- Overflow:
  - 64 writes of 0x01 -> the 64th write raises `wr_drop`;
  - then `start` with `addr`=1 -> header 0xFD, 63 bytes of 0x01, parity 0xFC (0xFD^0x01).
- Reset mid-packet: assert `reset` while PLD is on byte 2 -> next cycle `pkt_valid`=0, `data_out`=0, `tx_active`=0; a following `start` raises `start_rej`.

Source files
------------

// File: rtl/router_pkt_tx_pkg.sv
// router_pkg: shared types and constants for the router packet source.
//   tx_state_t      transmit FSM state encoding
//   ADDR_W, LEN_W   header field widths
//   MAX_LEN         largest payload the 6-bit length field can describe
//   HDR_*           bit positions of the header fields
//   make_hdr()      packs {len, addr} into a header byte
package router_pkg;

    localparam int ADDR_W  = 2;
    localparam int LEN_W   = 6;
    localparam int HDR_W   = LEN_W + ADDR_W;
    localparam int MAX_LEN = 63;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = HDR_ADDR_LSB + ADDR_W - 1;
    localparam int HDR_LEN_LSB  = HDR_ADDR_MSB + 1;
    localparam int HDR_LEN_MSB  = HDR_LEN_LSB + LEN_W - 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PLD  = 3'd2,
        PAR  = 3'd3,
        DONE = 3'd4
    } tx_state_t;

    function automatic logic [HDR_W-1:0] make_hdr(input logic [LEN_W-1:0]  len,
                                                  input logic [ADDR_W-1:0] dst);
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        h[HDR_ADDR_MSB:HDR_ADDR_LSB] = dst;
        return h;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: host-side and router-side signals of the packet source.
//   master : host / test side (drives writes, start, busy)
//   slave  : the packet source itself
// Signals: wr_en, wr_data, start, addr, inject_err, busy (host -> source);
//          pkt_valid, data_out, tx_active, tx_done, start_rej, wr_drop (source -> host).
interface router_pkt_tx_if #(parameter int DW = 8);
    import router_pkg::*;

    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic              inject_err;
    logic              busy;
    logic              pkt_valid;
    logic [DW-1:0]     data_out;
    logic              tx_active;
    logic              tx_done;
    logic              start_rej;
    logic              wr_drop;

    modport master (
        output wr_en, wr_data, start, addr, inject_err, busy,
        input  pkt_valid, data_out, tx_active, tx_done, start_rej, wr_drop
    );

    modport slave (
        input  wr_en, wr_data, start, addr, inject_err, busy,
        output pkt_valid, data_out, tx_active, tx_done, start_rej, wr_drop
    );

endinterface

// File: rtl/router_pkt_tx_buf.sv
// router_tx_buf: payload store, 2**LEN_W entries of DW bits.
//   clk      clock
//   wr_en    write strobe, wr_addr/wr_data captured on the rising edge
//   rd_addr  combinational read address, rd_data follows it directly
// The array has no reset; stale contents are never read because the read
// pointer never passes the current write count.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [LEN_W-1:0] wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [DW-1:0]    rd_data
);

    logic [DW-1:0] mem [2**LEN_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source feeding the router input port.
// Buffers payload bytes from the host, then on start emits
// header {len, addr}, the payload, and a parity byte, honouring busy.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    router_pkt_tx_if.slave (host writes/start, router busy, outputs)
//
// state | meaning
// IDLE  | accepting payload writes and start
// HDR   | header byte on data_out, pkt_valid high
// PLD   | payload byte on data_out, pkt_valid high
// PAR   | parity byte on data_out, pkt_valid low
// DONE  | tx_done pulse, buffer count and parity cleared
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN = router_pkg::MAX_LEN,
    parameter int DW      = 8
) (
    input logic            clk,
    input logic            reset,
    router_pkt_tx_if.slave bus
);

    localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_CNT  = LEN_W'(1);

    tx_state_t        state, state_nxt;
    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_ptr;
    logic [DW-1:0]    pay_par;
    logic [DW-1:0]    par_q;
    logic [DW-1:0]    rd_data;
    logic [DW-1:0]    hdr_new;

    logic [DW-1:0]    data_q, data_nxt;
    logic             valid_q, valid_nxt;
    logic             done_q, done_nxt;
    logic             start_rej_q;
    logic             wr_drop_q;

    logic consume;
    logic start_ok;
    logic start_zero;
    logic wr_ok;
    logic last_pld;
    logic adv_ptr;

    assign consume    = !bus.busy;
    assign start_ok   = (state == IDLE) && bus.start && (wr_cnt != '0);
    assign start_zero = (state == IDLE) && bus.start && (wr_cnt == '0);
    // A start in the same cycle takes priority over the write.
    assign wr_ok      = (state == IDLE) && bus.wr_en && !bus.start && (wr_cnt != FULL_CNT);
    // rd_ptr counts bytes already loaded onto the bus, so equality means the
    // last payload byte is the one currently presented.
    assign last_pld   = (rd_ptr == wr_cnt);
    assign adv_ptr    = consume && ((state == HDR) || ((state == PLD) && !last_pld));
    assign hdr_new    = DW'(make_hdr(wr_cnt, bus.addr));

    router_tx_buf #(.DW(DW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_cnt),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = HDR;
            HDR:     if (consume) state_nxt = PLD;
            PLD:     if (consume && last_pld) state_nxt = PAR;
            PAR:     if (consume) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered bus outputs; holding is the default so
    // busy freezes whatever byte is presented.
    always_comb begin
        data_nxt  = data_q;
        valid_nxt = valid_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    data_nxt  = hdr_new;
                    valid_nxt = 1'b1;
                end
            end
            HDR: begin
                if (consume) begin
                    data_nxt  = rd_data;
                    valid_nxt = 1'b1;
                end
            end
            PLD: begin
                if (consume) begin
                    if (last_pld) begin
                        data_nxt  = par_q;
                        valid_nxt = 1'b0;
                    end else begin
                        data_nxt  = rd_data;
                        valid_nxt = 1'b1;
                    end
                end
            end
            PAR: begin
                if (consume) begin
                    data_nxt  = '0;
                    valid_nxt = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                data_nxt  = '0;
                valid_nxt = 1'b0;
            end
            default: begin
                data_nxt  = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt      <= '0;
            pay_par     <= '0;
            rd_ptr      <= '0;
            par_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            start_rej_q <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            data_q      <= data_nxt;
            valid_q     <= valid_nxt;
            done_q      <= done_nxt;
            start_rej_q <= start_zero;
            wr_drop_q   <= bus.wr_en && !wr_ok;

            if (wr_ok) begin
                wr_cnt  <= wr_cnt + ONE_CNT;
                pay_par <= pay_par ^ bus.wr_data;
            end

            if (start_ok) begin
                par_q  <= pay_par ^ hdr_new ^ DW'(bus.inject_err);
                rd_ptr <= '0;
            end else if (adv_ptr) begin
                rd_ptr <= rd_ptr + ONE_CNT;
            end

            if (state == DONE) begin
                wr_cnt  <= '0;
                pay_par <= '0;
            end
        end
    end

    assign bus.pkt_valid = valid_q;
    assign bus.data_out  = data_q;
    assign bus.tx_active = (state != IDLE);
    assign bus.tx_done   = done_q;
    assign bus.start_rej = start_rej_q;
    assign bus.wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed table of packets, a few
// hand-written corner sequences, and randomized packets checked against an
// expected byte stream built from the packet format rules.
module tb_router_pkt_tx;

    logic clk;
    logic reset;

    router_pkt_tx_if #(.DW(8)) bus ();

    router_pkt_tx #(.MAX_LEN(63), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_buf[$];
    logic [7:0] exp_d[$];
    logic       exp_v[$];
    logic [7:0] obs_hdr;
    logic [7:0] obs_par;

    typedef struct {
        int              n;
        logic [3:0][7:0] pl;
        logic [1:0]      addr;
        logic            inj;
        logic            bp;
        logic [7:0]      exp_hdr;
        logic [7:0]      exp_par;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Writes bytes one per cycle; a write is expected to drop once 63 are held.
    task automatic write_bytes(input logic [7:0] q[$]);
        logic exp_drop;
        exp_drop = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            if (k > 0) chk("wr_drop", {31'b0, bus.wr_drop}, {31'b0, exp_drop});
            bus.wr_en   = 1'b1;
            bus.wr_data = q[k];
            exp_drop    = (model_buf.size() >= 63);
            if (!exp_drop) model_buf.push_back(q[k]);
        end
        @(negedge clk);
        if (q.size() > 0) chk("wr_drop_last", {31'b0, bus.wr_drop}, {31'b0, exp_drop});
        bus.wr_en = 1'b0;
    endtask

    // Issues start at the current negedge and builds the expected stream.
    task automatic do_start(input logic [1:0] a, input logic inj, input logic wr_also,
                            output logic accepted);
        int         n;
        logic [7:0] hdr;
        logic [7:0] par;
        n = model_buf.size();
        hdr = {n[5:0], a};
        par = hdr ^ {7'b0, inj};
        foreach (model_buf[k]) par = par ^ model_buf[k];
        exp_d.delete();
        exp_v.delete();
        exp_d.push_back(hdr);
        exp_v.push_back(1'b1);
        foreach (model_buf[k]) begin
            exp_d.push_back(model_buf[k]);
            exp_v.push_back(1'b1);
        end
        exp_d.push_back(par);
        exp_v.push_back(1'b0);

        bus.start      = 1'b1;
        bus.addr       = a;
        bus.inject_err = inj;
        bus.wr_en      = wr_also;
        bus.wr_data    = 8'hEE;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.inject_err = 1'b0;
        chk("start_rej", {31'b0, bus.start_rej}, {31'b0, (n == 0)});
        chk("wr_drop_start", {31'b0, bus.wr_drop}, {31'b0, wr_also});
        chk("tx_active_start", {31'b0, bus.tx_active}, {31'b0, (n > 0)});
        if (n == 0) chk("pkt_valid_rej", {31'b0, bus.pkt_valid}, 32'd0);
        accepted = (n > 0);
    endtask

    // busy_mode: 0 never busy, 1 random busy, 2 busy for two cycles on stream item 2.
    task automatic run_stream(input int busy_mode);
        int   idx;
        int   budget;
        int   bp_cnt;
        logic b;
        idx = 0;
        budget = 0;
        bp_cnt = 0;
        while (idx < exp_d.size() && budget < 400) begin
            chk("pkt_valid", {31'b0, bus.pkt_valid}, {31'b0, exp_v[idx]});
            chk("data_out", {24'b0, bus.data_out}, {24'b0, exp_d[idx]});
            chk("tx_done_early", {31'b0, bus.tx_done}, 32'd0);
            if (idx == 0) obs_hdr = bus.data_out;
            if (idx == exp_d.size() - 1) obs_par = bus.data_out;
            case (busy_mode)
                1:       b = ($urandom_range(0, 3) == 0);
                2:       b = (idx == 2) && (bp_cnt < 2);
                default: b = 1'b0;
            endcase
            if (b) bp_cnt++;
            bus.busy = b;
            if (!b) idx++;
            budget++;
            @(negedge clk);
        end
        bus.busy = 1'b0;
        chk("stream_timeout", idx, exp_d.size());
        chk("tx_done", {31'b0, bus.tx_done}, 32'd1);
        chk("pkt_valid_done", {31'b0, bus.pkt_valid}, 32'd0);
        chk("data_out_done", {24'b0, bus.data_out}, 32'd0);
        chk("tx_active_done", {31'b0, bus.tx_active}, 32'd1);
        model_buf.delete();
        @(negedge clk);
        chk("tx_done_pulse", {31'b0, bus.tx_done}, 32'd0);
        chk("tx_active_idle", {31'b0, bus.tx_active}, 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic       acc;

        tbl[0] = '{3, {8'h00, 8'h33, 8'h22, 8'h11}, 2'd2, 1'b0, 1'b0, 8'h0E, 8'h0E};
        tbl[1] = '{3, {8'h00, 8'h33, 8'h22, 8'h11}, 2'd2, 1'b0, 1'b1, 8'h0E, 8'h0E};
        tbl[2] = '{3, {8'h00, 8'h33, 8'h22, 8'h11}, 2'd2, 1'b1, 1'b0, 8'h0E, 8'h0F};
        tbl[3] = '{1, {8'h00, 8'h00, 8'h00, 8'hA5}, 2'd0, 1'b0, 1'b0, 8'h04, 8'hA1};
        tbl[4] = '{2, {8'h00, 8'h00, 8'h0F, 8'hFF}, 2'd3, 1'b1, 1'b1, 8'h0B, 8'hFA};

        bus.wr_en      = 1'b0;
        bus.wr_data    = 8'h00;
        bus.start      = 1'b0;
        bus.addr       = 2'd0;
        bus.inject_err = 1'b0;
        bus.busy       = 1'b0;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pkt_valid", {31'b0, bus.pkt_valid}, 32'd0);
        chk("rst_data_out", {24'b0, bus.data_out}, 32'd0);
        chk("rst_tx_active", {31'b0, bus.tx_active}, 32'd0);
        chk("rst_tx_done", {31'b0, bus.tx_done}, 32'd0);
        chk("rst_start_rej", {31'b0, bus.start_rej}, 32'd0);
        chk("rst_wr_drop", {31'b0, bus.wr_drop}, 32'd0);
        reset = 1'b0;

        // Zero-length start
        @(negedge clk);
        do_start(2'd1, 1'b0, 1'b0, acc);
        @(negedge clk);
        chk("start_rej_pulse", {31'b0, bus.start_rej}, 32'd0);
        chk("tx_active_rej", {31'b0, bus.tx_active}, 32'd0);

        // Directed table
        foreach (tbl[r]) begin
            q.delete();
            for (int k = 0; k < tbl[r].n; k++) q.push_back(tbl[r].pl[k]);
            write_bytes(q);
            do_start(tbl[r].addr, tbl[r].inj, 1'b0, acc);
            if (acc) run_stream(tbl[r].bp ? 2 : 0);
            chk("tbl_hdr", {24'b0, obs_hdr}, {24'b0, tbl[r].exp_hdr});
            chk("tbl_par", {24'b0, obs_par}, {24'b0, tbl[r].exp_par});
        end

        // Overflow: 64 writes, the last one dropped
        q.delete();
        for (int k = 0; k < 64; k++) q.push_back(8'h01);
        write_bytes(q);
        do_start(2'd1, 1'b0, 1'b0, acc);
        if (acc) run_stream(0);
        chk("ovf_hdr", {24'b0, obs_hdr}, 32'hFD);
        chk("ovf_par", {24'b0, obs_par}, 32'hFC);

        // Reset while the second payload byte is on the bus
        q.delete();
        q.push_back(8'h11);
        q.push_back(8'h22);
        q.push_back(8'h33);
        write_bytes(q);
        do_start(2'd2, 1'b0, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        chk("mid_byte2", {24'b0, bus.data_out}, 32'h22);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_valid", {31'b0, bus.pkt_valid}, 32'd0);
        chk("mid_rst_data", {24'b0, bus.data_out}, 32'd0);
        chk("mid_rst_active", {31'b0, bus.tx_active}, 32'd0);
        model_buf.delete();
        do_start(2'd0, 1'b0, 1'b0, acc);

        // Simultaneous write and start
        q.delete();
        q.push_back(8'h5A);
        q.push_back(8'hC3);
        write_bytes(q);
        do_start(2'd3, 1'b0, 1'b1, acc);
        if (acc) run_stream(0);

        // Randomized packets with random back-pressure
        for (int t = 0; t < 30; t++) begin
            int n;
            n = $urandom_range(0, 64);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            write_bytes(q);
            do_start(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), acc);
            if (acc) run_stream(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
